// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one synchronous-read VRAM port between the GPU
// fetch path (absolute priority, zero added latency) and a one-deep queued
// CPU request that is slotted into cycles where the GPU does not fetch.
// Optional build macro VRAM_ARB_STATS_EN adds the stat_wait / stat_max
// wait-cycle statistics outputs.
module vram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gpu_re,
    input  logic [ADDR_W-1:0] gpu_addr,
    output logic [DATA_W-1:0] gpu_q,
    input  logic              cpu_start,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic [DATA_W-1:0] cpu_q,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_d,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_q
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_wait,
    output logic [STAT_W-1:0] stat_max
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              done_q, done_d;

    // Next-state logic: latch a request in IDLE, wait for a free slot in
    // PEND, capture read data in RDATA.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_start) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    data_d  = cpu_data;
                    state_d = PEND;
                end
            end
            PEND: begin
                // The GPU owns the port whenever it fetches; retry next cycle.
                if (!gpu_re) begin
                    if (we_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end
            end
            RDATA: begin
                // vram_q now holds the CPU word addressed in the previous
                // cycle, whatever the GPU is issuing this cycle.
                rdata_d = vram_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before the edge, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Port mux: GPU first, then a pending CPU access, else park on addr_q.
    always_comb begin
        vram_d    = data_q;
        vram_addr = addr_q;
        vram_we   = 1'b0;
        if (gpu_re) begin
            vram_addr = gpu_addr;
        end else if (state_q == PEND) begin
            vram_we = we_q;
        end
        // A write must not reach the RAM in the very cycle reset is applied,
        // even though state_q still shows PEND until the edge.
        if (reset) begin
            vram_we = 1'b0;
        end
    end

    assign gpu_q    = vram_q;
    assign cpu_q    = rdata_q;
    assign cpu_done = done_q;
    assign cpu_busy = (state_q != IDLE);

`ifdef VRAM_ARB_STATS_EN
    logic [STAT_W-1:0] wait_q, wait_d;
    logic [STAT_W-1:0] max_q, max_d;
    logic [STAT_W-1:0] pend_len_q, pend_len_d;

    // Saturating statistics: total GPU-blocked cycles and longest PEND stay.
    always_comb begin
        wait_d     = wait_q;
        max_d      = max_q;
        pend_len_d = '0;
        if (state_q == PEND) begin
            pend_len_d = (pend_len_q == '1) ? pend_len_q : pend_len_q + STAT_W'(1);
            if (pend_len_d > max_q) begin
                max_d = pend_len_d;
            end
            if (gpu_re && (wait_q != '1)) begin
                wait_d = wait_q + STAT_W'(1);
            end
        end
    end

    // Statistics registers, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q     <= '0;
            max_q      <= '0;
            pend_len_q <= '0;
        end else begin
            wait_q     <= wait_d;
            max_q      <= max_d;
            pend_len_q <= pend_len_d;
        end
    end

    assign stat_wait = wait_q;
    assign stat_max  = max_q;
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: a per-cycle vector table plus
// hand-written sequences for long GPU blocking and reset mid-request.
module tb_vram_port_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int NVEC   = 27;

    logic              clk = 1'b0;
    logic              reset;
    logic              gpu_re;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_q;
    logic              cpu_start;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic [DATA_W-1:0] cpu_q;
    logic              cpu_busy;
    logic              cpu_done;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_d;
    logic              vram_we;
    logic [DATA_W-1:0] vram_q;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STAT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .gpu_re    (gpu_re),
        .gpu_addr  (gpu_addr),
        .gpu_q     (gpu_q),
        .cpu_start (cpu_start),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_q     (cpu_q),
        .cpu_busy  (cpu_busy),
        .cpu_done  (cpu_done),
        .vram_addr (vram_addr),
        .vram_d    (vram_d),
        .vram_we   (vram_we),
        .vram_q    (vram_q)
    );

    // VRAM model: untouched words read back a fixed pattern, writes are kept
    // in a shadow array; one-cycle synchronous read.
    logic [DATA_W-1:0] wmem    [0:(1<<ADDR_W)-1];
    bit                written [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        case (a)
            14'h0010: init_val = 32'h1234_5678;
            14'h0020: init_val = 32'h0BAD_C0DE;
            14'h0050: init_val = 32'h5050_5050;
            14'h0200: init_val = 32'hCAFE_F00D;
            default:  init_val = {4'hF, 14'h0, a};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        mem_rd = written[a] ? wmem[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (vram_we) begin
            wmem[vram_addr]    <= vram_d;
            written[vram_addr] <= 1'b1;
        end
        vram_q <= mem_rd(vram_addr);
    end

    typedef struct {
        logic              gre;
        logic [ADDR_W-1:0] gaddr;
        logic              start;
        logic              we;
        logic [ADDR_W-1:0] caddr;
        logic [DATA_W-1:0] cdata;
        logic              e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_d;
        logic              e_busy;
        logic              e_done;
        logic [DATA_W-1:0] e_q;
        logic              chk_g;
        logic [DATA_W-1:0] e_gq;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic gre, input logic [13:0] gaddr, input logic start, input logic we,
        input logic [13:0] caddr, input logic [31:0] cdata,
        input logic e_we, input logic [13:0] e_addr, input logic [31:0] e_d,
        input logic e_busy, input logic e_done, input logic [31:0] e_q,
        input logic chk_g, input logic [31:0] e_gq);
        vec_t v;
        v.gre = gre;   v.gaddr = gaddr; v.start = start; v.we = we;
        v.caddr = caddr; v.cdata = cdata;
        v.e_we = e_we; v.e_addr = e_addr; v.e_d = e_d;
        v.e_busy = e_busy; v.e_done = e_done; v.e_q = e_q;
        v.chk_g = chk_g; v.e_gq = e_gq;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic gre, input logic [ADDR_W-1:0] gaddr,
                         input logic start, input logic we,
                         input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cdata);
        gpu_re    = gre;
        gpu_addr  = gaddr;
        cpu_start = start;
        cpu_we    = we;
        cpu_addr  = caddr;
        cpu_data  = cdata;
    endtask

    // Advance to the next cycle: inputs change 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle table: inputs applied in cycle k, outputs checked
        // mid-cycle k (state reflects all earlier edges).
        //           gre gaddr    st we caddr    cdata         | we addr     vram_d        busy done cpu_q        chk gpu_q
        vecs[0]  = mk(1, 14'h3FFF, 0, 0, 14'h0000, 32'h0,        0, 14'h3FFF, 32'h0,        0, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 14'h0000, 1, 1, 14'h0123, 32'hDEADBEEF, 0, 14'h0000, 32'h0,        0, 0, 32'h0,        1, 32'hF0003FFF);
        vecs[2]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        1, 14'h0123, 32'hDEADBEEF, 1, 0, 32'h0,        0, 32'h0);
        vecs[3]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0123, 32'hDEADBEEF, 0, 1, 32'h0,        0, 32'h0);
        vecs[4]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0123, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0);
        vecs[5]  = mk(0, 14'h0000, 1, 0, 14'h0010, 32'h0,        0, 14'h0123, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0);
        vecs[6]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0010, 32'h0,        1, 0, 32'h0,        0, 32'h0);
        vecs[7]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0010, 32'h0,        1, 0, 32'h0,        1, 32'h12345678);
        vecs[8]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0010, 32'h0,        0, 1, 32'h12345678, 0, 32'h0);
        vecs[9]  = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0010, 32'h0,        0, 0, 32'h12345678, 0, 32'h0);
        vecs[10] = mk(0, 14'h0000, 1, 0, 14'h0020, 32'h0,        0, 14'h0010, 32'h0,        0, 0, 32'h12345678, 0, 32'h0);
        vecs[11] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0020, 32'h0,        1, 0, 32'h12345678, 0, 32'h0);
        vecs[12] = mk(1, 14'h0200, 0, 0, 14'h0000, 32'h0,        0, 14'h0200, 32'h0,        1, 0, 32'h12345678, 1, 32'h0BADC0DE);
        vecs[13] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0020, 32'h0,        0, 1, 32'h0BADC0DE, 1, 32'hCAFEF00D);
        vecs[14] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0020, 32'h0,        0, 0, 32'h0BADC0DE, 0, 32'h0);
        vecs[15] = mk(1, 14'h0300, 1, 1, 14'h0040, 32'h11111111, 0, 14'h0300, 32'h0,        0, 0, 32'h0BADC0DE, 0, 32'h0);
        vecs[16] = mk(1, 14'h0301, 1, 1, 14'h0050, 32'h22222222, 0, 14'h0301, 32'h11111111, 1, 0, 32'h0BADC0DE, 0, 32'h0);
        vecs[17] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        1, 14'h0040, 32'h11111111, 1, 0, 32'h0BADC0DE, 0, 32'h0);
        vecs[18] = mk(0, 14'h0000, 1, 0, 14'h0040, 32'h0,        0, 14'h0040, 32'h11111111, 0, 1, 32'h0BADC0DE, 0, 32'h0);
        vecs[19] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0040, 32'h0,        1, 0, 32'h0BADC0DE, 0, 32'h0);
        vecs[20] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0040, 32'h0,        1, 0, 32'h0BADC0DE, 1, 32'h11111111);
        vecs[21] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0040, 32'h0,        0, 1, 32'h11111111, 0, 32'h0);
        vecs[22] = mk(0, 14'h0000, 1, 0, 14'h0050, 32'h0,        0, 14'h0040, 32'h0,        0, 0, 32'h11111111, 0, 32'h0);
        vecs[23] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0050, 32'h0,        1, 0, 32'h11111111, 0, 32'h0);
        vecs[24] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0050, 32'h0,        1, 0, 32'h11111111, 1, 32'h50505050);
        vecs[25] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0050, 32'h0,        0, 1, 32'h50505050, 0, 32'h0);
        vecs[26] = mk(0, 14'h0000, 0, 0, 14'h0000, 32'h0,        0, 14'h0050, 32'h0,        0, 0, 32'h50505050, 0, 32'h0);

        // Reset with a start pulse present: nothing may be latched.
        reset = 1'b1;
        drive(0, 14'h0, 1, 1, 14'h0777, 32'h5555AAAA);
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset_vram_we", -1, 32'(vram_we), 32'h0);
        next_cycle();
        reset = 1'b0;
        drive(0, 14'h0, 0, 0, 14'h0, 32'h0);
        @(negedge clk);
        check("reset_busy",  -1, 32'(cpu_busy), 32'h0);
        check("reset_done",  -1, 32'(cpu_done), 32'h0);
        check("reset_cpu_q", -1, cpu_q,         32'h0);
        check("reset_addr",  -1, 32'(vram_addr), 32'h0);
        next_cycle();

        // Table-driven section.
        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].gre, vecs[k].gaddr, vecs[k].start, vecs[k].we,
                  vecs[k].caddr, vecs[k].cdata);
            @(negedge clk);
            check("vram_we",   k, 32'(vram_we),   32'(vecs[k].e_we));
            check("vram_addr", k, 32'(vram_addr), 32'(vecs[k].e_addr));
            check("vram_d",    k, vram_d,         vecs[k].e_d);
            check("cpu_busy",  k, 32'(cpu_busy),  32'(vecs[k].e_busy));
            check("cpu_done",  k, 32'(cpu_done),  32'(vecs[k].e_done));
            check("cpu_q",     k, cpu_q,          vecs[k].e_q);
            if (vecs[k].chk_g) begin
                check("gpu_q", k, gpu_q, vecs[k].e_gq);
            end
            next_cycle();
        end
        check("mem_0123", -1, mem_rd(14'h0123), 32'hDEADBEEF);
        check("mem_0040", -1, mem_rd(14'h0040), 32'h11111111);
        check("mem_0050_untouched", -1, mem_rd(14'h0050), 32'h50505050);

        // Long GPU blocking: a queued write must wait out 100 fetch cycles.
        drive(0, 14'h0, 1, 1, 14'h0777, 32'hA1B2C3D4);
        next_cycle();
        for (int i = 0; i < 100; i++) begin
            drive(1, 14'(14'h1000 + i), 0, 0, 14'h0, 32'h0);
            @(negedge clk);
            check("block_we",   i, 32'(vram_we),   32'h0);
            check("block_addr", i, 32'(vram_addr), 32'(14'h1000 + i));
            check("block_busy", i, 32'(cpu_busy),  32'h1);
            check("block_done", i, 32'(cpu_done),  32'h0);
            next_cycle();
        end
        drive(0, 14'h0, 0, 0, 14'h0, 32'h0);
        @(negedge clk);
        check("unblock_we",   -1, 32'(vram_we),   32'h1);
        check("unblock_addr", -1, 32'(vram_addr), 32'h0777);
        check("unblock_d",    -1, vram_d,         32'hA1B2C3D4);
        next_cycle();
        @(negedge clk);
        check("unblock_done", -1, 32'(cpu_done), 32'h1);
        check("unblock_busy", -1, 32'(cpu_busy), 32'h0);
        next_cycle();
        check("mem_0777", -1, mem_rd(14'h0777), 32'hA1B2C3D4);

        // Reset while a write is pending and the port is free.
        drive(0, 14'h0, 1, 1, 14'h0888, 32'h99999999);
        next_cycle();
        drive(0, 14'h0, 0, 0, 14'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pend_we", -1, 32'(vram_we), 32'h0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_pend_busy", -1, 32'(cpu_busy), 32'h0);
        check("rst_pend_done", -1, 32'(cpu_done), 32'h0);
        check("rst_pend_cpu_q", -1, cpu_q, 32'h0);
        next_cycle();
        @(negedge clk);
        check("rst_pend_done2", -1, 32'(cpu_done), 32'h0);
        check("mem_0888_untouched", -1, mem_rd(14'h0888), 32'hF0000888);
        next_cycle();

        // A fresh request after that reset completes normally.
        drive(0, 14'h0, 1, 1, 14'h0888, 32'h77777777);
        next_cycle();
        drive(0, 14'h0, 0, 0, 14'h0, 32'h0);
        @(negedge clk);
        check("post_rst_we",   -1, 32'(vram_we),   32'h1);
        check("post_rst_addr", -1, 32'(vram_addr), 32'h0888);
        next_cycle();
        @(negedge clk);
        check("post_rst_done", -1, 32'(cpu_done), 32'h1);
        next_cycle();
        check("mem_0888", -1, mem_rd(14'h0888), 32'h77777777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
